// File: rtl/stream_rr_arbiter_pkg.sv
// Shared definitions for the stream round-robin arbiter: the arbitration
// state encoding and a ceiling-log2 helper for sizing index fields.
package stream_rr_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_t;

    // Ceiling log2, minimum result 1 so single-entry indices stay one bit wide.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/stream_skid_buffer.sv
// Two-entry valid/ready register stage (main + skid). Upstream ready is a
// register (skid entry empty), so no combinational path runs from i_ready to
// o_ready, while back-to-back transfers still run at one beat per cycle.
module stream_skid_buffer
    import stream_rr_arbiter_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         iCLK,
    input  logic         iRST,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         r_acc;
    logic         r_mvld;
    logic [W-1:0] r_main;
    logic [W-1:0] r_skid;
    logic         w_in;
    logic         w_main_free;

    assign w_in        = i_valid & r_acc;
    assign w_main_free = ~r_mvld | i_ready;

    // Occupancy control: skid only fills when main is held, and empties
    // into main the first cycle main drains.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_acc  <= 1'b1;
            r_mvld <= 1'b0;
        end else if (!r_acc) begin
            if (i_ready) r_acc <= 1'b1;
        end else if (w_in) begin
            if (w_main_free) r_mvld <= 1'b1;
            else             r_acc  <= 1'b0;
        end else if (i_ready) begin
            r_mvld <= 1'b0;
        end
    end

    // Payload registers follow the same routing; they need no reset because
    // the valid flags above qualify them.
    always_ff @(posedge iCLK) begin
        if (!r_acc) begin
            if (i_ready) r_main <= r_skid;
        end else if (w_in) begin
            if (w_main_free) r_main <= i_data;
            else             r_skid <= i_data;
        end
    end

    assign o_ready = r_acc;
    assign o_valid = r_mvld;
    assign o_data  = r_main;

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin packet arbiter: N valid/ready requester streams share one
// output stage. A grant is held from the first beat of a packet until its
// last beat; the search pointer then moves past the winner so continuously
// valid requesters are served in turn.
module stream_rr_arbiter
    import stream_rr_arbiter_pkg::*;
#(
    parameter int N     = 4,
    parameter int WIDTH = 64,
    parameter int IDW   = 2
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic [N-1:0]       iValid_AM,
    output logic [N-1:0]       oReady_AM,
    input  logic [N*WIDTH-1:0] iData_AM,
    input  logic [N-1:0]       iLast_AM,
    output logic               oValid_BM,
    input  logic               iReady_BM,
    output logic [WIDTH-1:0]   oData_BM,
    output logic               oLast_BM,
    output logic [IDW-1:0]     oId_BM
);

    localparam int BW = WIDTH + 1 + IDW;

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_lock;
    logic [IDW-1:0]   w_ptr_nxt;
    logic [IDW-1:0]   w_lock_nxt;
    logic [IDW-1:0]   w_ptr_inc;

    logic [N-1:0]     w_rot;
    logic [IDW-1:0]   w_off;
    logic             w_found;
    logic [IDW:0]     w_sum;
    logic [IDW-1:0]   w_gnt;
    logic             w_gnt_vld;

    logic             w_sel_valid;
    logic             w_sel_last;
    logic [WIDTH-1:0] w_sel_data;
    logic             w_acc;
    logic             w_xfer;
    logic [BW-1:0]    w_buf_out;

    // Requests rotated so that bit 0 is the requester at the pointer.
    assign w_rot = N'({iValid_AM, iValid_AM} >> r_ptr);

    // Grant selection: locked owner, else first valid requester from the pointer.
    always_comb begin
        w_off     = '0;
        w_found   = 1'b0;
        w_sum     = '0;
        w_gnt     = '0;
        w_gnt_vld = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!w_found && w_rot[j]) begin
                w_found = 1'b1;
                w_off   = IDW'(j);
            end
        end
        if (r_state == ST_LOCK) begin
            w_gnt     = r_lock;
            w_gnt_vld = 1'b1;
        end else begin
            w_sum = {1'b0, r_ptr} + {1'b0, w_off};
            if (w_sum >= (IDW+1)'(N)) w_sum = w_sum - (IDW+1)'(N);
            w_gnt     = w_sum[IDW-1:0];
            w_gnt_vld = w_found;
        end
    end

    // Steer the granted requester's beat and drive its one-hot ready.
    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        oReady_AM   = '0;
        for (int k = 0; k < N; k++) begin
            if (w_gnt == IDW'(k)) begin
                w_sel_valid  = iValid_AM[k];
                w_sel_last   = iLast_AM[k];
                w_sel_data   = iData_AM[k*WIDTH +: WIDTH];
                oReady_AM[k] = w_gnt_vld & w_acc;
            end
        end
    end

    assign w_xfer    = w_gnt_vld & w_sel_valid & w_acc;
    assign w_ptr_inc = (w_gnt == IDW'(N-1)) ? '0 : w_gnt + 1'b1;

    // Arbitration next state: lock on a non-last beat, release and rotate on last.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_lock_nxt  = r_lock;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    if (w_sel_last) begin
                        w_ptr_nxt = w_ptr_inc;
                    end else begin
                        w_lock_nxt  = w_gnt;
                        w_state_nxt = ST_LOCK;
                    end
                end
            end
            ST_LOCK: begin
                if (w_xfer && w_sel_last) begin
                    w_ptr_nxt   = w_ptr_inc;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_lock  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_lock  <= w_lock_nxt;
        end
    end

    stream_skid_buffer #(
        .W(BW)
    ) u_buf (
        .iCLK    (iCLK),
        .iRST    (iRST),
        .i_valid (w_gnt_vld & w_sel_valid),
        .o_ready (w_acc),
        .i_data  ({w_sel_last, w_gnt, w_sel_data}),
        .o_valid (oValid_BM),
        .i_ready (iReady_BM),
        .o_data  (w_buf_out)
    );

    assign oData_BM = w_buf_out[WIDTH-1:0];
    assign oId_BM   = w_buf_out[WIDTH +: IDW];
    assign oLast_BM = w_buf_out[BW-1];

endmodule
